// File: rtl/hilo_unit_if.sv
// HI/LO unit bus: issue strobes and operands from EX, the divider handshake, and read/stall back to EX.
interface hilo_unit_if;
    logic        OP_mult, OP_multu, OP_div, OP_divu, OP_mthi, OP_mtlo;
    logic        OP_mfhi, OP_mflo;
    logic [31:0] rs_data, rt_data;
    logic        div_op_div, div_op_divu;
    logic [31:0] div_dividend, div_divisor;
    logic [31:0] div_quotient, div_remainder;
    logic        div_stall;
    logic [31:0] read_data;
    logic        stall;

    modport slave (
        input  OP_mult, OP_multu, OP_div, OP_divu, OP_mthi, OP_mtlo, OP_mfhi, OP_mflo,
        input  rs_data, rt_data, div_quotient, div_remainder, div_stall,
        output div_op_div, div_op_divu, div_dividend, div_divisor, read_data, stall
    );

    modport master (
        output OP_mult, OP_multu, OP_div, OP_divu, OP_mthi, OP_mtlo, OP_mfhi, OP_mflo,
        output rs_data, rt_data, div_quotient, div_remainder, div_stall,
        input  div_op_div, div_op_divu, div_dividend, div_divisor, read_data, stall
    );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO register unit: two-stage multiplier, external divider tracking, MTHI/MTLO writes and MFHI/MFLO reads.
module hilo_unit (
    input  logic       clock,
    input  logic       reset,
    hilo_unit_if.slave hilo
);
    logic [31:0] hi, lo;
    logic        mul_v1, mul_v2, div_pend, div_seen, rem_neg;
    logic [32:0] mul_a, mul_b;
    logic [63:0] product, mul_prod;
    logic        busy, any_op, accept, div_commit;
    logic        sel_mult, sel_multu, sel_div, sel_divu, sel_mthi, sel_mtlo;

    assign busy   = mul_v1 | mul_v2 | div_pend;
    assign any_op = hilo.OP_mult | hilo.OP_multu | hilo.OP_div | hilo.OP_divu |
                    hilo.OP_mthi | hilo.OP_mtlo | hilo.OP_mfhi | hilo.OP_mflo;
    assign accept = !busy && !reset;

    // Fixed priority: mult > multu > div > divu > mthi > mtlo.
    always_comb begin
        sel_mult  = accept & hilo.OP_mult;
        sel_multu = accept & !hilo.OP_mult & hilo.OP_multu;
        sel_div   = accept & !hilo.OP_mult & !hilo.OP_multu & hilo.OP_div;
        sel_divu  = accept & !hilo.OP_mult & !hilo.OP_multu & !hilo.OP_div & hilo.OP_divu;
        sel_mthi  = accept & !hilo.OP_mult & !hilo.OP_multu & !hilo.OP_div & !hilo.OP_divu
                    & hilo.OP_mthi;
        sel_mtlo  = accept & !hilo.OP_mult & !hilo.OP_multu & !hilo.OP_div & !hilo.OP_divu
                    & !hilo.OP_mthi & hilo.OP_mtlo;
    end

    assign hilo.stall        = !reset & busy & any_op;
    assign hilo.div_op_div   = sel_div;
    assign hilo.div_op_divu  = sel_divu;
    assign hilo.div_dividend = hilo.rs_data;
    assign hilo.div_divisor  = hilo.rt_data;
    assign hilo.read_data    = reset        ? 32'd0 :
                               hilo.OP_mfhi ? hi    :
                               hilo.OP_mflo ? lo    : 32'd0;

    // Operands are already 33-bit extended, so sign-extending to 64 gives the exact low 64 bits.
    assign mul_prod   = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};
    assign div_commit = div_pend & div_seen & !hilo.div_stall;

    always_ff @(posedge clock) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            mul_v1   <= 1'b0;
            mul_v2   <= 1'b0;
            div_pend <= 1'b0;
            div_seen <= 1'b0;
            rem_neg  <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            product  <= '0;
        end else begin
            mul_v1 <= sel_mult | sel_multu;
            if (sel_mult | sel_multu) begin
                mul_a <= {sel_mult & hilo.rs_data[31], hilo.rs_data};
                mul_b <= {sel_mult & hilo.rt_data[31], hilo.rt_data};
            end
            mul_v2 <= mul_v1;
            if (mul_v1) product <= mul_prod;

            // Writers are mutually exclusive: MT only when idle, commits only while busy.
            if (mul_v2) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end else if (div_commit) begin
                lo <= hilo.div_quotient;
                hi <= rem_neg ? -hilo.div_remainder : hilo.div_remainder;
            end else if (sel_mthi) begin
                hi <= hilo.rs_data;
            end else if (sel_mtlo) begin
                lo <= hilo.rs_data;
            end

            if (sel_div | sel_divu) begin
                div_pend <= 1'b1;
                div_seen <= 1'b0;
                rem_neg  <= sel_div & hilo.rs_data[31];
            end else if (div_commit) begin
                div_pend <= 1'b0;
            end else if (div_pend & hilo.div_stall) begin
                div_seen <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with a fixed-latency behavioural divider (signed quotient, remainder magnitude).
module tb_hilo_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hilo_unit_if hilo ();
    hilo_unit dut (.clock(clock), .reset(reset), .hilo(hilo));

    int errs = 0;
    int checks = 0;

    // Behavioural divider: busy for 4 cycles after a start strobe.
    logic [2:0] dcnt;
    logic       stall_force = 1'b0;
    assign hilo.div_stall = (dcnt != 3'd0) | stall_force;
    always @(posedge clock) begin
        if (reset) begin
            dcnt <= 3'd0;
            hilo.div_quotient  <= 32'd0;
            hilo.div_remainder <= 32'd0;
        end else if (hilo.div_op_div || hilo.div_op_divu) begin
            dcnt <= 3'd4;
            if (hilo.div_divisor == 32'd0) begin
                hilo.div_quotient  <= 32'hFFFF_FFFF;
                hilo.div_remainder <= hilo.div_dividend;
            end else if (hilo.div_op_div) begin
                automatic logic signed [31:0] a = hilo.div_dividend;
                automatic logic signed [31:0] b = hilo.div_divisor;
                automatic logic signed [31:0] r = a % b;
                hilo.div_quotient  <= a / b;
                hilo.div_remainder <= (r < 0) ? -r : r;
            end else begin
                hilo.div_quotient  <= hilo.div_dividend / hilo.div_divisor;
                hilo.div_remainder <= hilo.div_dividend % hilo.div_divisor;
            end
        end else if (dcnt != 3'd0) begin
            dcnt <= dcnt - 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ops();
        hilo.OP_mult = 0; hilo.OP_multu = 0; hilo.OP_div = 0; hilo.OP_divu = 0;
        hilo.OP_mthi = 0; hilo.OP_mtlo = 0; hilo.OP_mfhi = 0; hilo.OP_mflo = 0;
    endtask

    task automatic rd(input logic sel_hi, output logic [31:0] v);
        hilo.OP_mfhi = sel_hi;
        hilo.OP_mflo = !sel_hi;
        #1;
        v = hilo.read_data;
        hilo.OP_mfhi = 0;
        hilo.OP_mflo = 0;
    endtask

    // Hold an MFLO request until the unit stops stalling; n = stalled cycles.
    task automatic wait_idle(output int n);
        hilo.OP_mflo = 1;
        #1;
        n = 0;
        while (hilo.stall && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_mult(input string tag, input logic u, input logic [31:0] a, b,
                           input logic [31:0] ehi, elo);
        logic [31:0] v;
        hilo.OP_mult = !u; hilo.OP_multu = u; hilo.rs_data = a; hilo.rt_data = b;
        #1;
        chk({tag, "_accept_stall"}, 32'(hilo.stall), 32'd0);
        step();
        clear_ops();
        hilo.OP_mflo = 1;
        #1;
        chk({tag, "_stall_n1"}, 32'(hilo.stall), 32'd1);
        step();
        chk({tag, "_stall_n2"}, 32'(hilo.stall), 32'd1);
        step();
        chk({tag, "_stall_n3"}, 32'(hilo.stall), 32'd0);
        chk({tag, "_lo"}, hilo.read_data, elo);
        hilo.OP_mflo = 0;
        rd(1'b1, v);
        chk({tag, "_hi"}, v, ehi);
    endtask

    task automatic issue_div(input string tag, input logic u, input logic [31:0] a, b);
        hilo.OP_div = !u; hilo.OP_divu = u; hilo.rs_data = a; hilo.rt_data = b;
        #1;
        chk({tag, "_op"}, {30'd0, hilo.div_op_div, hilo.div_op_divu}, u ? 32'd1 : 32'd2);
        chk({tag, "_dvd"}, hilo.div_dividend, a);
        chk({tag, "_dvs"}, hilo.div_divisor, b);
        step();
        clear_ops();
    endtask

    task automatic do_div(input string tag, input logic u, input logic [31:0] a, b,
                          input logic [31:0] ehi, elo);
        int n;
        logic [31:0] v;
        issue_div(tag, u, a, b);
        wait_idle(n);
        chk({tag, "_stall_cycles"}, 32'(n), 32'd5);
        chk({tag, "_lo"}, hilo.read_data, elo);
        hilo.OP_mflo = 0;
        rd(1'b1, v);
        chk({tag, "_hi"}, v, ehi);
    endtask

    initial begin
        int n;
        logic [31:0] v;
        logic pulse;
        clear_ops();
        hilo.rs_data = 32'd100; hilo.rt_data = 32'd7;

        // Outputs stay quiet during reset even with strobes up.
        hilo.OP_div = 1; hilo.OP_mfhi = 1;
        #1;
        chk("rst_stall", 32'(hilo.stall), 32'd0);
        chk("rst_divop", 32'(hilo.div_op_div), 32'd0);
        chk("rst_rdata", hilo.read_data, 32'd0);
        step(); step();
        chk("rst_rdata2", hilo.read_data, 32'd0);
        reset = 0;
        clear_ops();
        rd(1'b1, v); chk("rst_hi", v, 32'd0);
        rd(1'b0, v); chk("rst_lo", v, 32'd0);
        step();

        do_mult("mult",  1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        step();
        do_mult("multu", 1'b1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
        step();
        do_mult("mult_neg2", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        step();

        do_div("div_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
        step();
        do_div("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        step();
        do_div("divu_big", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC);
        step();

        // MTHI then MFHI next cycle, never stalling.
        hilo.OP_mthi = 1; hilo.rs_data = 32'h1234_5678;
        #1; chk("mthi_stall", 32'(hilo.stall), 32'd0);
        step(); clear_ops();
        hilo.OP_mfhi = 1;
        #1;
        chk("mfhi_stall", 32'(hilo.stall), 32'd0);
        chk("mfhi_data", hilo.read_data, 32'h1234_5678);
        clear_ops();
        hilo.OP_mtlo = 1; hilo.rs_data = 32'hCAFE_F00D;
        step(); clear_ops();
        rd(1'b0, v); chk("mtlo_data", v, 32'hCAFE_F00D);
        step();

        // Priority: mthi beats mtlo, LO untouched.
        hilo.OP_mthi = 1; hilo.OP_mtlo = 1; hilo.rs_data = 32'h0000_0011;
        step(); clear_ops();
        rd(1'b1, v); chk("pri_mthi_hi", v, 32'h0000_0011);
        rd(1'b0, v); chk("pri_mthi_lo", v, 32'hCAFE_F00D);
        step();

        // Priority: mult beats div and mthi.
        hilo.OP_mult = 1; hilo.OP_div = 1; hilo.OP_mthi = 1;
        hilo.rs_data = 32'd2; hilo.rt_data = 32'd4;
        #1; chk("pri_mult_divop", 32'(hilo.div_op_div), 32'd0);
        step(); clear_ops(); step(); step();
        rd(1'b0, v); chk("pri_mult_lo", v, 32'd8);
        rd(1'b1, v); chk("pri_mult_hi", v, 32'd0);
        step();

        // Priority: div beats divu.
        hilo.OP_div = 1; hilo.OP_divu = 1;
        hilo.rs_data = 32'hFFFF_FFF9; hilo.rt_data = 32'd2;
        #1; chk("pri_div_op", {30'd0, hilo.div_op_div, hilo.div_op_divu}, 32'd2);
        step(); clear_ops();
        wait_idle(n);
        chk("pri_div_lo", hilo.read_data, 32'hFFFF_FFFD);
        clear_ops();
        step();

        // MULT held against a pending DIV: stalls, no divider pulse, accepted after commit.
        issue_div("blk_div", 1'b0, 32'd100, 32'd7);
        hilo.OP_mult = 1; hilo.rs_data = 32'd5; hilo.rt_data = 32'd6;
        #1;
        n = 0; pulse = 0;
        while (hilo.stall && n < 20) begin
            pulse = pulse | hilo.div_op_div | hilo.div_op_divu;
            step();
            n++;
        end
        chk("blk_stall_cycles", 32'(n), 32'd5);
        chk("blk_no_divop", 32'(pulse), 32'd0);
        step(); clear_ops(); step(); step();
        rd(1'b0, v); chk("blk_mult_lo", v, 32'd30);
        rd(1'b1, v); chk("blk_mult_hi", v, 32'd0);
        step();

        // Reset mid-divide: state cleared, later stall fall writes nothing.
        issue_div("rst_div", 1'b0, 32'd100, 32'd7);
        step();
        reset = 1;
        step();
        reset = 0;
        hilo.OP_mflo = 1;
        #1; chk("rstdiv_busy", 32'(hilo.stall), 32'd0);
        clear_ops();
        stall_force = 1; step();
        stall_force = 0; step(); step();
        rd(1'b1, v); chk("rstdiv_hi", v, 32'd0);
        rd(1'b0, v); chk("rstdiv_lo", v, 32'd0);
        step();

        // Reset mid-multiply abandons the product.
        hilo.OP_mult = 1; hilo.rs_data = 32'd9; hilo.rt_data = 32'd9;
        step(); clear_ops();
        reset = 1; step();
        reset = 0; step(); step(); step();
        rd(1'b0, v); chk("rstmul_lo", v, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
